// File: rtl/mem_read_arbiter_if.sv
// Bundle between the read arbiter, its requester engines and the memory
// read port. The arbiter sits on the slave modport; requesters plus memory
// together form the master side.
// Optional feature macro: MEM_ARB_BOUNDS_CHECK_EN (adds adr_err).
interface mem_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADR_W   = 8,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*ADR_W-1:0] start_adr;
  logic [NUM_REQ*LEN_W-1:0] len;
  logic [ADR_W-1:0]         rd_adr;
  logic [DATA_W-1:0]        rd_data;
  logic [NUM_REQ-1:0]       gnt;
  logic [DATA_W-1:0]        data_out;
  logic                     data_valid;
  logic [ID_W-1:0]          data_id;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
  logic                     adr_err;
`endif

  modport slave (
    input  req, start_adr, len, rd_data,
    output rd_adr, gnt, data_out, data_valid, data_id, done, busy
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    , output adr_err
`endif
  );

  modport master (
    output req, start_adr, len, rd_data,
    input  rd_adr, gnt, data_out, data_valid, data_id, done, busy
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    , input adr_err
`endif
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one combinational memory read port among
// NUM_REQ requesters. The winner receives a burst of len consecutive words
// from its start address as a registered stream tagged with its ID.
// Optional feature macro: MEM_ARB_BOUNDS_CHECK_EN -- words captured from an
// address >= MAX_MEM_SIZE are replaced by zero and flagged on adr_err.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests
// BURST | rd_adr walks the owner's window, one word captured per cycle
// DONE  | single cycle: grant still held, done pulse to the owner
module mem_read_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADR_W        = 8,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 8,
  parameter int MAX_MEM_SIZE = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_read_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [ADR_W-1:0]     adr_q, adr_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 valid_q, valid_d;
  logic [ID_W-1:0]      id_q, id_d;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
  logic                 err_q, err_d;
`endif

  logic                 found_hi, found_any;
  logic [ID_W-1:0]      win_hi, win_any, win;

  // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    win_hi    = '0;
    win_any   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        found_any = 1'b1;
        win_any   = ID_W'(i);
        if (i >= int'(ptr_q)) begin
          found_hi = 1'b1;
          win_hi   = ID_W'(i);
        end
      end
    end
    win = found_hi ? win_hi : win_any;
  end

  // Next-state and next-register values for the burst sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    data_d  = data_q;
    valid_d = 1'b0;
    id_d    = id_q;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found_any) begin
          owner_d = win;
          gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          adr_d   = bus.start_adr[win*ADR_W +: ADR_W];
          len_d   = bus.len[win*LEN_W +: LEN_W];
          cnt_d   = '0;
          if (len_d == '0) begin
            state_d = DONE;
            done_d  = gnt_d;
          end else begin
            state_d = BURST;
          end
        end
      end
      BURST: begin
`ifdef MEM_ARB_BOUNDS_CHECK_EN
        if (int'(adr_q) >= MAX_MEM_SIZE) begin
          data_d = '0;
          err_d  = 1'b1;
        end else begin
          data_d = bus.rd_data;
        end
`else
        data_d  = bus.rd_data;
`endif
        valid_d = 1'b1;
        id_d    = owner_q;
        adr_d   = adr_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == len_q - 1'b1) begin
          state_d = DONE;
          done_d  = gnt_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        adr_d   = '0;
        cnt_d   = '0;
        ptr_d   = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      adr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      id_q    <= id_d;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.rd_adr     = (state_q == BURST) ? adr_q : '0;
  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.data_id    = id_q;
  assign bus.busy       = (state_q != IDLE);
`ifdef MEM_ARB_BOUNDS_CHECK_EN
  assign bus.adr_err    = err_q;
`endif
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed scenarios followed by random traffic,
// all checked each cycle against a schedule-based expectation model.
`timescale 1ns/1ps
module tb_mem_read_arbiter;
  localparam int N    = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int LW   = 8;
  localparam int MAXM = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_read_arbiter_if #(.NUM_REQ(N), .ADR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  mem_read_arbiter #(
    .NUM_REQ(N), .ADR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_MEM_SIZE(MAXM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [N-1:0]    req_v   = '0;
  logic [N*AW-1:0] start_v = '0;
  logic [N*LW-1:0] len_v   = '0;
  logic [DW-1:0]   mem [256];

  assign bus.req       = req_v;
  assign bus.start_adr = start_v;
  assign bus.len       = len_v;
  assign bus.rd_data   = mem[bus.rd_adr];

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- expectation model ----------------
  typedef struct {
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic          dv;
    logic [DW-1:0] data;
    logic [1:0]    id;
    logic          busy;
    logic          chk_adr;
    logic [AW-1:0] adr;
    logic          err;
  } exp_t;

  exp_t          cur;
  exp_t          sched[$];
  int            m_ptr;
  logic [DW-1:0] m_last;

  function automatic logic oob(logic [AW-1:0] a);
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    return int'(a) >= MAXM;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] word_at(logic [AW-1:0] a);
    if (oob(a)) return '0;
    return mem[a];
  endfunction

  function automatic exp_t idle_rec(logic [DW-1:0] d);
    exp_t e;
    e.gnt = '0; e.done = '0; e.dv = 1'b0; e.data = d; e.id = '0;
    e.busy = 1'b0; e.chk_adr = 1'b1; e.adr = '0; e.err = 1'b0;
    return e;
  endfunction

  task automatic m_reset();
    sched.delete();
    m_ptr  = 0;
    m_last = '0;
    cur    = idle_rec('0);
  endtask

  // Expand a granted burst into its full per-cycle output schedule.
  task automatic m_build();
    int            o;
    int            L;
    logic [AW-1:0] s;
    logic [AW-1:0] a;
    logic [N-1:0]  oh;
    logic [DW-1:0] last;
    exp_t          e;
    o = -1;
    for (int k = 0; k < N; k++)
      if (o < 0 && req_v[(m_ptr + k) % N]) o = (m_ptr + k) % N;
    s    = start_v[o*AW +: AW];
    L    = int'(len_v[o*LW +: LW]);
    oh   = N'(1 << o);
    last = m_last;
    for (int k = 0; k <= L; k++) begin
      e.gnt     = oh;
      e.busy    = 1'b1;
      e.id      = 2'(o);
      e.done    = (k == L) ? oh : '0;
      e.dv      = (k > 0);
      e.chk_adr = (k < L);
      e.adr     = s + AW'(k);
      if (k > 0) begin
        a      = s + AW'(k - 1);
        e.data = word_at(a);
        e.err  = oob(a);
        last   = e.data;
      end else begin
        e.data = last;
        e.err  = 1'b0;
      end
      sched.push_back(e);
    end
    m_ptr = (o + 1) % N;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      if (sched.size() == 0 && !cur.busy && req_v != '0) m_build();
      if (sched.size() > 0) cur = sched.pop_front();
      else cur = idle_rec(m_last);
      if (cur.dv) m_last = cur.data;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("gnt", 32'(bus.gnt), 32'(cur.gnt));
    chk("done", 32'(bus.done), 32'(cur.done));
    chk("data_valid", 32'(bus.data_valid), 32'(cur.dv));
    chk("busy", 32'(bus.busy), 32'(cur.busy));
    chk("data_out", bus.data_out, cur.data);
    if (cur.dv) chk("data_id", 32'(bus.data_id), 32'(cur.id));
    if (cur.chk_adr) chk("rd_adr", 32'(bus.rd_adr), 32'(cur.adr));
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    chk("adr_err", 32'(bus.adr_err), 32'(cur.err));
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [AW-1:0] s, logic [LW-1:0] l);
    start_v[i*AW +: AW] = s;
    len_v[i*LW +: LW]   = l;
    req_v[i]            = 1'b1;
  endtask

  task automatic wait_gnt(logic [N-1:0] expg, string name);
    int n = 0;
    while (bus.gnt == '0 && n < 50) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.gnt), 32'(expg));
  endtask

  task automatic wait_done_drop(logic [N-1:0] expd, string name, int budget);
    int n = 0;
    while (bus.done == '0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.done), 32'(expd));
    req_v = req_v & ~expd;
    tick();
    chk({name, "_gnt_off"}, 32'(bus.gnt), 32'(0));
  endtask

  function automatic logic [LW-1:0] rand_len();
    int r = $urandom_range(0, 15);
    if (r == 0) return '0;
    if (r == 15) return LW'($urandom_range(9, 20));
    return LW'($urandom_range(1, 8));
  endfunction

  function automatic logic [AW-1:0] rand_start();
    if ($urandom_range(0, 3) == 0) return AW'(8'hFA + $urandom_range(0, 5));
    return AW'($urandom);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 32'hD000_0000 | DW'(i);

    // reset held five cycles
    rst_n = 1'b0;
    repeat (5) tick();
    chk("rst_gnt", 32'(bus.gnt), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_valid", 32'(bus.data_valid), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_rd_adr", 32'(bus.rd_adr), 32'(0));
    rst_n = 1'b1;
    tick();

    // single burst of three words from 0x10
    set_req(0, 8'h10, 8'd3);
    tick();
    chk("b3_gnt", 32'(bus.gnt), 32'h1);
    chk("b3_valid0", 32'(bus.data_valid), 32'(0));
    chk("b3_adr0", 32'(bus.rd_adr), 32'h10);
    tick();
    chk("b3_w0", bus.data_out, 32'hD000_0010);
    chk("b3_id", 32'(bus.data_id), 32'(0));
    tick();
    chk("b3_w1", bus.data_out, 32'hD000_0011);
    tick();
    chk("b3_w2", bus.data_out, 32'hD000_0012);
    chk("b3_done", 32'(bus.done), 32'h1);
    chk("b3_valid2", 32'(bus.data_valid), 32'(1));
    req_v[0] = 1'b0;
    tick();
    chk("b3_gnt_off", 32'(bus.gnt), 32'(0));
    chk("b3_valid_off", 32'(bus.data_valid), 32'(0));

    // round robin after a fresh reset: 0101 then 1010
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    set_req(0, 8'h20, 8'd1);
    set_req(2, 8'h30, 8'd2);
    wait_gnt(4'b0001, "rr_first_req0");
    wait_done_drop(4'b0001, "rr_done_req0", 20);
    wait_gnt(4'b0100, "rr_then_req2");
    wait_done_drop(4'b0100, "rr_done_req2", 20);
    set_req(1, 8'h40, 8'd1);
    set_req(3, 8'h50, 8'd1);
    wait_gnt(4'b1000, "rr_req3_before_req1");
    wait_done_drop(4'b1000, "rr_done_req3", 20);
    wait_gnt(4'b0010, "rr_then_req1");
    wait_done_drop(4'b0010, "rr_done_req1", 20);

    // address wrap FE,FF,00,01
    set_req(0, 8'hFE, 8'd4);
    tick();
    chk("wrap_gnt", 32'(bus.gnt), 32'h1);
    a = 8'hFE;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_rd_adr", 32'(bus.rd_adr), 32'(a));
      tick();
      chk("wrap_valid", 32'(bus.data_valid), 32'(1));
      chk("wrap_data", bus.data_out, word_at(a));
      a = a + 8'd1;
    end
    chk("wrap_done", 32'(bus.done), 32'h1);
    req_v[0] = 1'b0;
    tick();
    chk("wrap_no_extra", 32'(bus.data_valid), 32'(0));

    // zero-length burst on req1
    set_req(1, 8'h00, 8'd0);
    tick();
    chk("len0_gnt", 32'(bus.gnt), 32'h2);
    chk("len0_done", 32'(bus.done), 32'h2);
    chk("len0_valid", 32'(bus.data_valid), 32'(0));
    req_v[1] = 1'b0;
    tick();
    chk("len0_gnt_off", 32'(bus.gnt), 32'(0));
    chk("len0_busy_off", 32'(bus.busy), 32'(0));

    // maximum length burst
    set_req(2, 8'h05, 8'hFF);
    wait_gnt(4'b0100, "max_gnt");
    wait_done_drop(4'b0100, "max_done", 300);

    // reset on the second word of a len=8 burst
    set_req(2, 8'h60, 8'd8);
    wait_gnt(4'b0100, "abort_gnt");
    tick();
    chk("abort_adr_2nd", 32'(bus.rd_adr), 32'h61);
    rst_n = 1'b0;
    #1;
    chk("abort_gnt0", 32'(bus.gnt), 32'(0));
    chk("abort_valid0", 32'(bus.data_valid), 32'(0));
    chk("abort_done0", 32'(bus.done), 32'(0));
    chk("abort_busy0", 32'(bus.busy), 32'(0));
    chk("abort_data0", bus.data_out, 32'(0));
    req_v[2] = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    set_req(1, 8'h70, 8'd1);
    set_req(3, 8'h78, 8'd1);
    wait_gnt(4'b0010, "ptr_restart_req1");
    wait_done_drop(4'b0010, "ptr_done_req1", 20);
    wait_gnt(4'b1000, "post_abort_req3");
    wait_done_drop(4'b1000, "post_abort_done3", 20);

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    set_req(0, 8'h7F, 8'd2);
    tick();
    tick();
    chk("bnd_w0", bus.data_out, 32'hD000_007F);
    chk("bnd_err0", 32'(bus.adr_err), 32'(0));
    tick();
    chk("bnd_w1", bus.data_out, 32'(0));
    chk("bnd_err1", 32'(bus.adr_err), 32'(1));
    chk("bnd_done", 32'(bus.done), 32'h1);
    req_v[0] = 1'b0;
    tick();
    chk("bnd_err_clr", 32'(bus.adr_err), 32'(0));
`endif

    // random traffic with one mid-run reset
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (c == 2000) rst_n = 1'b0;
      if (c == 2003) rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (bus.done[i]) begin
          req_v[i] = 1'b0;
        end else if (!req_v[i]) begin
          if ($urandom_range(0, 3) == 0) set_req(i, rand_start(), rand_len());
        end else if (bus.gnt[i] && $urandom_range(0, 7) == 0) begin
          start_v[i*AW +: AW] = AW'($urandom);
          len_v[i*LW +: LW]   = LW'($urandom);
          if ($urandom_range(0, 3) == 0) req_v[i] = 1'b0;
        end
      end
    end
    req_v = '0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
